fp_addsub_arbiter: RTL and testbench

Round-robin scheduler that shares one single-precision floating-point adder/subtractor instance among `NREQ` requesters. It accepts one operation at a time over per-requester valid/ready handshakes and registers the operands toward the shared combinational adder. It captures the result and status flags, then returns them on a single tagged response channel. It sits between the requesting units and the one adder instance at the arithmetic block's top level.

---
 rtl/fp_addsub_arbiter_if.sv | 27 ++
 rtl/fp_addsub_arbiter.sv | 125 ++++++++++++
 tb/tb_fp_addsub_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_arbiter_if.sv
// Request and response channels between requesters, the shared-adder
// arbiter and the response consumer.
interface fp_addsub_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    req_sub;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_res;
    logic [2:0]         rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags
    );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// Round-robin scheduler sharing one combinational FP adder/subtractor
// among NREQ requesters; one operation in flight, tagged response.
module fp_addsub_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_addsub_arbiter_if.slave  bus,
    output logic [31:0]         fpu_a,
    output logic [31:0]         fpu_b,
    input  logic [31:0]         fpu_res,
    input  logic                fpu_uf,
    input  logic                fpu_of,
    input  logic                fpu_exc,
    output logic                busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_id_q;
    logic [31:0]    r_fpu_a;
    logic [31:0]    r_fpu_b;
    logic [31:0]    r_rsp_res;
    logic [2:0]     r_rsp_flags;
    logic [IDW-1:0] r_rsp_id;
    logic           r_busy;

    logic           w_found;
    logic [IDW-1:0] w_gidx;
    logic [IDW-1:0] w_next_ptr;
    logic [31:0]    w_a;
    logic [31:0]    w_b;
    logic           w_sub;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        int j;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!w_found && bus.req_valid[j]) begin
                w_found = 1'b1;
                w_gidx  = IDW'(j);
            end
        end
    end

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_sub = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gidx == IDW'(k)) begin
                w_a   = bus.req_a[32*k +: 32];
                w_b   = bus.req_b[32*k +: 32];
                w_sub = bus.req_sub[k];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && r_state == S_IDLE && w_found)
            bus.req_ready[w_gidx] = 1'b1;
    end

    assign w_next_ptr = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_id_q      <= '0;
            r_fpu_a     <= '0;
            r_fpu_b     <= '0;
            r_rsp_res   <= '0;
            r_rsp_flags <= '0;
            r_rsp_id    <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_fpu_a  <= w_a;
                        r_fpu_b  <= {w_b[31] ^ w_sub, w_b[30:0]};
                        r_id_q   <= w_gidx;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_EXEC;
                        r_busy   <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_rsp_res   <= fpu_res;
                    r_rsp_flags <= {fpu_exc, fpu_of, fpu_uf};
                    r_rsp_id    <= r_id_q;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fpu_a         = r_fpu_a;
    assign fpu_b         = r_fpu_b;
    assign busy          = r_busy;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_res   = r_rsp_res;
    assign bus.rsp_flags = r_rsp_flags;
    assign bus.rsp_id    = r_rsp_id;
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench for fp_addsub_arbiter: expected responses are queued
// at issue time and a negedge monitor pops and compares them.
module tb_fp_addsub_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    res;
        logic [2:0]     flags;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [31:0] fpu_res;
    logic        fpu_uf;
    logic        fpu_of;
    logic        fpu_exc;
    logic        busy;
    logic        exc_mode;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    fp_addsub_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    fp_addsub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .fpu_a   (fpu_a),
        .fpu_b   (fpu_b),
        .fpu_res (fpu_res),
        .fpu_uf  (fpu_uf),
        .fpu_of  (fpu_of),
        .fpu_exc (fpu_exc),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder stand-in: a table of exact single-precision sums
    always_comb begin
        fpu_uf  = 1'b0;
        fpu_of  = 1'b0;
        fpu_exc = 1'b0;
        fpu_res = 32'hDEADBEEF;
        if (exc_mode) begin
            fpu_exc = 1'b1;
            fpu_res = 32'h0;
        end else begin
            case ({fpu_a, fpu_b})
                {32'h3F800000, 32'h40000000}: fpu_res = 32'h40400000;
                {32'h40400000, 32'hBF800000}: fpu_res = 32'h40000000;
                {32'h40000000, 32'h40000000}: fpu_res = 32'h40800000;
                {32'h3F800000, 32'h3F800000}: fpu_res = 32'h40000000;
                {32'h40800000, 32'hBF800000}: fpu_res = 32'h40400000;
                default:                      fpu_res = 32'hDEADBEEF;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id %0d expected none",
                         bus.rsp_id);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                chk("rsp_res", bus.rsp_res, e.res);
                chk("rsp_flags", 32'(bus.rsp_flags), 32'(e.flags));
            end
        end
    end

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic sub);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_sub[i]        = sub;
        bus.req_valid[i]      = 1'b1;
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 after the RESP cycle
    task automatic op(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic [31:0] er,
                      input logic [2:0] ef, input bit push);
        exp_t e;
        set_req(i, a, b, sub);
        if (push) begin
            e.id    = IDW'(i);
            e.res   = er;
            e.flags = ef;
            q.push_back(e);
        end
        @(negedge clk);
        chk("grant", 32'(bus.req_ready), 32'(1 << i));
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
        @(negedge clk);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_no_valid", 32'(bus.rsp_valid), 32'd0);
        chk("fpu_a", fpu_a, a);
        chk("fpu_b", fpu_b, {b[31] ^ sub, b[30:0]});
        @(posedge clk); #1;
        @(negedge clk);
        chk("latency_valid", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20; k++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ord[5];
        int n;
        int last;
        ord = '{0, 1, 2, 3, 0};
        exc_mode      = 1'b0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, with a request pending that must not be accepted
        repeat (2) @(posedge clk);
        #1;
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_fpu_a", fpu_a, 32'd0);
        chk("rst_fpu_b", fpu_b, 32'd0);
        chk("rst_res", bus.rsp_res, 32'd0);
        chk("rst_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_flags", 32'(bus.rsp_flags), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        rst_n = 1'b1;

        // Single add, then subtract
        op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1);
        op(2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 1);
        wait_drain();

        // All requesters valid: rotation and spacing
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        set_req(1, 32'h40400000, 32'h3F800000, 1'b1);
        set_req(2, 32'h40000000, 32'h40000000, 1'b0);
        set_req(3, 32'h3F800000, 32'h3F800000, 1'b0);
        q.push_back('{id: 2'd0, res: 32'h40400000, flags: 3'b000});
        q.push_back('{id: 2'd1, res: 32'h40000000, flags: 3'b000});
        q.push_back('{id: 2'd2, res: 32'h40800000, flags: 3'b000});
        q.push_back('{id: 2'd3, res: 32'h40000000, flags: 3'b000});
        q.push_back('{id: 2'd0, res: 32'h40400000, flags: 3'b000});
        n = 0;
        last = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                chk("rr_grant", 32'(bus.req_ready), 32'(1 << ord[n]));
                if (n > 0) chk("rr_spacing", 32'(c - last), 32'd3);
                last = c;
                n++;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        chk("rr_grant_count", 32'(n), 32'd5);
        wait_drain();

        // Backpressure with requester 3 waiting
        bus.rsp_ready = 1'b0;
        set_req(3, 32'h40800000, 32'h3F800000, 1'b1);
        op(1, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_res", bus.rsp_res, 32'h40000000);
            chk("bp_id", 32'(bus.rsp_id), 32'd1);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        op(3, 32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 3'b000, 1);
        wait_drain();

        // Reset while in RESP drops the operation
        bus.rsp_ready = 1'b0;
        op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h0, 3'b000, 0);
        set_req(1, 32'h40400000, 32'h3F800000, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_res", bus.rsp_res, 32'd0);
        chk("mid_rst_id", 32'(bus.rsp_id), 32'd0);
        chk("mid_rst_flags", 32'(bus.rsp_flags), 32'd0);
        chk("mid_rst_fpu_a", fpu_a, 32'd0);
        chk("mid_rst_fpu_b", fpu_b, 32'd0);
        chk("mid_rst_grant", 32'(bus.req_ready), 32'b0010);
        q.push_back('{id: 2'd1, res: 32'h40000000, flags: 3'b000});
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_drain();

        // Exception flag and zero result pass through unchanged
        exc_mode = 1'b1;
        op(2, 32'h3F800000, 32'h40000000, 1'b0, 32'h0, 3'b100, 1);
        wait_drain();
        exc_mode = 1'b0;

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
